gbsha_fir_mac: RTL and testbench
================================

Name: gbsha_fir_mac

Overview:
Parametrised, coefficient-programmable FIR filter with signed samples and coefficients. It replaces the fixed delay line with a real filter. The block computes y = sum over k of coef[k]*x[k], where x[0] is the newest sample, using one shared multiplier over N_TAPS sequential MAC cycles. The result is arithmetically shifted and saturated to the output width. It sits directly behind the 8-bit pad mux of the tile; the same data pins load either samples or coefficients, selected by mode.

Parameters:
N_TAPS, 8, number of taps (>=2)
BW_IN, 6, signed sample width
BW_COEF, 4, signed coefficient width (<= BW_IN; taken from x_in LSBs)
BW_OUT, 6, signed output width
OUT_SHIFT, 0, arithmetic right shift applied to accumulator before saturation

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
mode  input  1  0 = sample, 1 = coefficient load
in_valid  input  1  x_in carries a sample/coefficient this cycle
x_in  input  BW_IN  signed sample, or coefficient in [BW_COEF-1:0]
in_ready  output  1  high only in IDLE; a transfer occurs when in_valid && in_ready
y_out  output  BW_OUT  signed filtered result, held until the next result
y_valid  output  1  one-cycle pulse when y_out is updated

Behaviour:
- Accumulator width ACC_W = BW_IN + BW_COEF + clog2(N_TAPS); all arithmetic is signed; products are sign-extended to ACC_W.
- Reset (synchronous): state=IDLE, delay line x[*]=0, acc=0, y_out=0, y_valid=0, coef[0]=1, coef[1..N_TAPS-1]=0 (identity filter). in_ready=1 in the cycle after reset.
- States: IDLE, MAC, OUT.
- IDLE, mode=1, transfer:
  - coef[N_TAPS-1] <= x_in[BW_COEF-1:0]; coef[k] <= coef[k+1].
  - After N_TAPS loads, the first loaded value is in coef[0].
  - State stays IDLE; the delay line is untouched.
- IDLE, mode=0, transfer at cycle t:
  - x[0] <= x_in; x[k] <= x[k-1]; acc <= 0; tap index <= 0; go to MAC.
- MAC, cycles t+1..t+N_TAPS: acc += coef[i]*x[i], i = 0..N_TAPS-1. On the last tap, go to OUT.
- OUT, cycle t+N_TAPS+1:
  - y_out = sat(acc >>> OUT_SHIFT) to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1]; y_valid=1 for this cycle only.
  - Next state is IDLE.
- Latency: y_valid asserts N_TAPS+1 cycles after acceptance. Throughput: 1 sample per N_TAPS+2 cycles.
- in_valid, mode and x_in are ignored while in MAC or OUT; nothing is queued.
- Shift is floor (arithmetic, no rounding). Saturation is applied after the shift.
- Reset mid-MAC/OUT: the operation is aborted, no y_valid is issued, and all reset values apply, including identity coefficients.
- in_ready is combinational from the state (state==IDLE). All other outputs are registered.

Decomposition:
- Package gbsha_fir_pkg holds:
  - the state enum (IDLE/MAC/OUT);
  - an ACC_W helper function;
  - localparams for the saturation bounds.
- Sub-module gbsha_fir_sat is parametrised on ACC_W, BW_OUT and OUT_SHIFT. It is a purely combinational arithmetic shift plus saturation and is unit-testable on its own.
- The delay line, coefficient bank, MAC datapath and FSM stay in gbsha_fir_mac.

Test Plan (defaults):
1. Reset, then feed sample 5 with mode=0 -> in_ready drops next cycle; y_valid pulses exactly 9 cycles after acceptance with y_out=5. Feed -7 -> y_out=-7.
2. Load eight coefficients of 1, then feed 8 samples of 3 -> 8th output =24. Feed 8 samples of 4 -> final output saturates to 31.
3. Load eight coefficients of 7, then feed 8 samples of -32 -> accumulator -1792, y_out=-32 (negative saturation).
4. Hold in_valid=1 continuously with changing x_in -> exactly one acceptance per 10 cycles; values presented during MAC/OUT never enter the delay line.
5. Assert reset during the 4th MAC cycle -> no y_valid. The next sample 9 yields y_out=9, proving identity coefficients and a zero delay line.
6. Toggle mode=1 with in_valid during MAC -> coefficients unchanged, verified by a repeat of scenario 2 giving the same result.

Source files
------------

// File: rtl/gbsha_fir_pkg.sv
// Shared types and helpers for the coefficient-programmable FIR MAC:
// FSM states, accumulator width rule and output saturation bounds.
package gbsha_fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Wide enough for N_TAPS full-scale products without overflow.
   function automatic int acc_width(input int bw_in, input int bw_coef, input int n_taps);
      return bw_in + bw_coef + $clog2(n_taps);
   endfunction

   localparam int DEF_BW_OUT = 6;
   localparam int SAT_HI     = (1 << (DEF_BW_OUT - 1)) - 1;
   localparam int SAT_LO     = -(1 << (DEF_BW_OUT - 1));

endpackage

// File: rtl/gbsha_fir_mac_if.sv
// Sample/coefficient load channel and result channel of the FIR MAC.
// The tile's pad mux side is the master; the filter is the slave.
interface gbsha_fir_mac_if #(
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 6
);
   logic                     mode;
   logic                     in_valid;
   logic signed [BW_IN-1:0]  x_in;
   logic                     in_ready;
   logic signed [BW_OUT-1:0] y_out;
   logic                     y_valid;

   modport master (
      output mode, in_valid, x_in,
      input  in_ready, y_out, y_valid
   );

   modport slave (
      input  mode, in_valid, x_in,
      output in_ready, y_out, y_valid
   );
endinterface

// File: rtl/gbsha_fir_sat.sv
// Combinational floor arithmetic right shift followed by saturation of the
// accumulator into the signed output range.
module gbsha_fir_sat
   import gbsha_fir_pkg::*;
#(
   parameter int ACC_W     = 13,
   parameter int BW_OUT    = 6,
   parameter int OUT_SHIFT = 0
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [BW_OUT-1:0] y
);
   localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shifted = acc >>> OUT_SHIFT;
      if (shifted > HI) begin
         y = HI[BW_OUT-1:0];
      end else if (shifted < LO) begin
         y = LO[BW_OUT-1:0];
      end else begin
         y = shifted[BW_OUT-1:0];
      end
   end
endmodule

// File: rtl/gbsha_fir_mac.sv
// Coefficient-programmable FIR filter: one shared multiplier walks the taps
// sequentially, then the sum is shifted and saturated to the output width.
module gbsha_fir_mac
   import gbsha_fir_pkg::*;
#(
   parameter int N_TAPS    = 8,
   parameter int BW_IN     = 6,
   parameter int BW_COEF   = 4,
   parameter int BW_OUT    = 6,
   parameter int OUT_SHIFT = 0
) (
   input  logic            clk,
   input  logic            reset,
   gbsha_fir_mac_if.slave  bus
);
   localparam int ACC_W  = acc_width(BW_IN, BW_COEF, N_TAPS);
   localparam int IDX_W  = $clog2(N_TAPS);
   localparam int PROD_W = BW_IN + BW_COEF;

   state_t                    state, state_next;
   logic signed [BW_IN-1:0]   x_dl [N_TAPS];
   logic signed [BW_COEF-1:0] coef [N_TAPS];
   logic signed [ACC_W-1:0]   acc;
   logic [IDX_W-1:0]          tap_idx;

   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [BW_OUT-1:0]  sat_y;
   logic                      last_tap;
   logic                      take;

   assign take         = bus.in_valid && (state == IDLE);
   assign last_tap     = (tap_idx == IDX_W'(N_TAPS - 1));
   assign bus.in_ready = (state == IDLE);

   always_comb begin
      prod    = coef[tap_idx] * x_dl[tap_idx];
      acc_sum = acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
   end

   gbsha_fir_sat #(
      .ACC_W     (ACC_W),
      .BW_OUT    (BW_OUT),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_sat (
      .acc (acc_sum),
      .y   (sat_y)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: state_next gets a default before the case so no path infers a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (take && !bus.mode) state_next = MAC;
         MAC:     if (last_tap) state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The final product is folded in while registering the output, so y_valid
   // is high exactly during the OUT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the arrays are reset on purpose: identity coefficients and a clear delay line are visible behaviour.
         for (int k = 0; k < N_TAPS; k++) begin
            x_dl[k] <= '0;
            coef[k] <= '0;
         end
         coef[0] <= BW_COEF'(1);
         acc     <= '0;
         tap_idx <= '0;
         bus.y_out   <= '0;
         bus.y_valid <= 1'b0;
      end else begin
         bus.y_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (take && bus.mode) begin
                  for (int k = 0; k < N_TAPS - 1; k++) coef[k] <= coef[k+1];
                  coef[N_TAPS-1] <= $signed(bus.x_in[BW_COEF-1:0]);
               end else if (take) begin
                  x_dl[0] <= bus.x_in;
                  for (int k = 1; k < N_TAPS; k++) x_dl[k] <= x_dl[k-1];
                  acc     <= '0;
                  tap_idx <= '0;
               end
            end
            MAC: begin
               acc     <= acc_sum;
               tap_idx <= tap_idx + IDX_W'(1);
               if (last_tap) begin
                  bus.y_out   <= sat_y;
                  bus.y_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_gbsha_fir_mac.sv
// Directed self-checking bench for gbsha_fir_mac with default parameters
// (8 taps, 6-bit samples, 4-bit coefficients, 6-bit output, no shift).
module tb_gbsha_fir_mac;
   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   gbsha_fir_mac_if #(.BW_IN(6), .BW_OUT(6)) bus ();

   gbsha_fir_mac #(
      .N_TAPS(8), .BW_IN(6), .BW_COEF(4), .BW_OUT(6), .OUT_SHIFT(0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want summary before it");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // All tasks start and end on a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic xfer(input logic m, input logic signed [5:0] v);
      int n;
      n = 0;
      while (!bus.in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("ready_timeout", bus.in_ready, 1);
      bus.mode     = m;
      bus.in_valid = 1'b1;
      bus.x_in     = v;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.mode     = 1'b0;
   endtask

   task automatic run_sample(input logic signed [5:0] v, input bit do_chk, input int exp, input string tag);
      int lat;
      xfer(1'b0, v);
      check({tag, "_ready_low"}, bus.in_ready, 0);
      lat = 1;
      while (!bus.y_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 9);
      if (do_chk) check({tag, "_y"}, bus.y_out, exp);
      @(negedge clk);
      check({tag, "_pulse"}, bus.y_valid, 0);
   endtask

   initial begin
      int saw;
      int exp4 [3];
      logic signed [5:0] v;

      bus.mode     = 1'b0;
      bus.in_valid = 1'b0;
      bus.x_in     = '0;
      reset        = 1'b1;
      @(negedge clk);
      do_reset();
      check("rst_ready", bus.in_ready, 1);
      check("rst_y", bus.y_out, 0);
      check("rst_valid", bus.y_valid, 0);

      // 1: identity filter after reset
      run_sample(6'sd5, 1'b1, 5, "t1_pos");
      run_sample(-6'sd7, 1'b1, -7, "t1_neg");

      // 2: all-ones coefficients, sum of eight samples
      repeat (8) xfer(1'b1, 6'sd1);
      for (int i = 0; i < 8; i++) run_sample(6'sd3, i == 7, 24, "t2_sum24");
      for (int i = 0; i < 8; i++) run_sample(6'sd4, i == 7, 31, "t2_sat_pos");

      // 3: coefficients of 7; first output 7*(-32+7*4) = -28, final -1792 saturates
      repeat (8) xfer(1'b1, 6'sd7);
      run_sample(-6'sd32, 1'b1, -28, "t3_first");
      for (int i = 1; i < 8; i++) run_sample(-6'sd32, i == 7, -32, "t3_sat_neg");

      // 5: reset in the 4th MAC cycle aborts and restores identity
      xfer(1'b0, 6'sd20);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      saw = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.y_valid) saw++;
      end
      check("t5_no_valid", saw, 0);
      check("t5_ready", bus.in_ready, 1);
      run_sample(6'sd9, 1'b1, 9, "t5_identity");

      // 4: continuous in_valid, coef = {1,1,0,...}; y = x[0] + x[1]
      do_reset();
      xfer(1'b1, 6'sd1);
      xfer(1'b1, 6'sd1);
      repeat (6) xfer(1'b1, 6'sd0);
      exp4[0] = -6;          // v(0)
      exp4[1] = 4 - 6;       // v(10) + v(0)
      exp4[2] = 1 + 4;       // v(20) + v(10)
      for (int c = 0; c < 30; c++) begin
         check($sformatf("t4_ready_c%0d", c), bus.in_ready, (c % 10 == 0) ? 1 : 0);
         if (c % 10 == 9) begin
            check($sformatf("t4_valid_c%0d", c), bus.y_valid, 1);
            check($sformatf("t4_y_c%0d", c), bus.y_out, exp4[c / 10]);
         end
         v = 6'((c % 13) - 6);
         bus.mode     = 1'b0;
         bus.in_valid = 1'b1;
         bus.x_in     = v;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (12) @(negedge clk);

      // 6: coefficient-load attempts during MAC are ignored
      repeat (8) xfer(1'b1, 6'sd1);
      xfer(1'b0, 6'sd3);
      for (int i = 0; i < 8; i++) begin
         bus.mode     = 1'b1;
         bus.in_valid = 1'b1;
         bus.x_in     = 6'sd5;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.mode     = 1'b0;
      check("t6_valid", bus.y_valid, 1);
      check("t6_y", bus.y_out, 2);   // 3 + 1 + 4 - 6 from the t4 delay line
      @(negedge clk);
      for (int i = 0; i < 8; i++) run_sample(6'sd3, i == 7, 24, "t6_sum24");
      for (int i = 0; i < 8; i++) run_sample(6'sd4, i == 7, 31, "t6_sat_pos");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
